// File: rtl/successive_arith_unit.sv
// ============================================================================
// Module   : successive_arith_unit
// Purpose  : Sequential unsigned multiply/divide coprocessor. Multiply is done
//            by repeated addition and divide by repeated subtraction, one step
//            per clock. Operands are latched with start; results are held
//            between operations.
// Ports    : clk          - rising-edge clock
//            reset        - asynchronous, active-low reset
//            start        - operation request (sampled in IDLE only)
//            op           - 0 = multiply, 1 = divide
//            a, b         - multiplicand/dividend, multiplier/divisor
//            busy         - high while RUN or DONE
//            done         - one-cycle pulse when results are valid
//            result_lo    - product low half / quotient
//            result_hi    - product high half / remainder
//            div_by_zero  - set when the last completed divide had b == 0
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module successive_arith_unit #(
  parameter int WIDTH    = 8,
  parameter int SWAP_OPT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);

  localparam int ACC_W = 2 * WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               op_q, op_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   addend_q, addend_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   res_lo_q, res_lo_d;
  logic [WIDTH-1:0]   res_hi_q, res_hi_d;
  logic               dbz_q, dbz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Multiply setup: iteration count and the operand that gets accumulated.
  logic [WIDTH-1:0]   count_init;
  logic [WIDTH-1:0]   addend_init;

  generate
    if (SWAP_OPT != 0) begin : g_swap
      // Iterate over the smaller operand to minimise cycle count.
      assign count_init  = (a < b) ? a : b;
      assign addend_init = (a < b) ? b : a;
    end else begin : g_noswap
      assign count_init  = b;
      assign addend_init = a;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      op_q     <= 1'b0;
      b_q      <= '0;
      cnt_q    <= '0;
      addend_q <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      dbz_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      addend_q <= addend_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      dbz_q    <= dbz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    addend_d = addend_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    dbz_d    = dbz_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d     = op;
          b_d      = b;
          cnt_d    = count_init;
          addend_d = {{WIDTH{1'b0}}, addend_init};
          acc_d    = '0;
          rem_d    = a;
          quo_d    = '0;
          // A zero divisor also passes through one RUN cycle, so every
          // operation completes at least one edge after it is accepted.
          state_d  = ST_RUN;
        end
      end

      ST_RUN: begin
        if (!op_q) begin
          if (cnt_q != '0) begin
            acc_d = acc_q + addend_q;
            cnt_d = cnt_q - WIDTH'(1);
          end else begin
            res_lo_d = acc_q[WIDTH-1:0];
            res_hi_d = acc_q[ACC_W-1:WIDTH];
            dbz_d    = 1'b0;
            state_d  = ST_DONE;
          end
        end else if (b_q == '0) begin
          // rem_q still holds the untouched dividend here.
          res_lo_d = '1;
          res_hi_d = rem_q;
          dbz_d    = 1'b1;
          state_d  = ST_DONE;
        end else if (rem_q >= b_q) begin
          rem_d = rem_q - b_q;
          quo_d = quo_q + WIDTH'(1);
        end else begin
          res_lo_d = quo_q;
          res_hi_d = rem_q;
          dbz_d    = 1'b0;
          state_d  = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status flags are registered from the next state so they line up
    // exactly with the state register.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result_lo   = res_lo_q;
  assign result_hi   = res_hi_q;
  assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_successive_arith_unit.sv
`default_nettype none

module tb_successive_arith_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [7:0]  result_lo;
  logic [7:0]  result_hi;
  logic        div_by_zero;

  logic        w_start;
  logic        w_op;
  logic [11:0] w_a;
  logic [11:0] w_b;
  logic        w_busy;
  logic        w_done;
  logic [11:0] w_result_lo;
  logic [11:0] w_result_hi;
  logic        w_div_by_zero;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] res;
    logic        dbz;
    int          lat;
  } exp8_t;

  typedef struct {
    logic [23:0] res;
    int          lat;
  } exp12_t;

  exp8_t  sb[$];
  exp12_t wsb[$];

  successive_arith_unit #(.WIDTH(8), .SWAP_OPT(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .result_lo   (result_lo),
    .result_hi   (result_hi),
    .div_by_zero (div_by_zero)
  );

  successive_arith_unit #(.WIDTH(12), .SWAP_OPT(0)) dut_w (
    .clk         (clk),
    .reset       (reset),
    .start       (w_start),
    .op          (w_op),
    .a           (w_a),
    .b           (w_b),
    .busy        (w_busy),
    .done        (w_done),
    .result_lo   (w_result_lo),
    .result_hi   (w_result_hi),
    .div_by_zero (w_div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one 8-bit operation, push its model result, wait for done and
  // compare. When inject is set, a spurious start with other operands is
  // pulsed during RUN and must have no effect.
  task automatic run_op(input logic o, input logic [7:0] x, input logic [7:0] y,
                        input bit inject);
    exp8_t e;
    exp8_t g;
    int    cyc;
    bit    got;
    if (!o) begin
      e.res = {8'h00, x} * {8'h00, y};
      e.dbz = 1'b0;
      e.lat = ((x < y) ? int'(x) : int'(y)) + 1;
    end else if (y == 8'd0) begin
      e.res = {x, 8'hFF};
      e.dbz = 1'b1;
      e.lat = 1;
    end else begin
      e.res = {x % y, x / y};
      e.dbz = 1'b0;
      e.lat = int'(x / y) + 1;
    end
    sb.push_back(e);

    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 8'h5A; b = 8'hC3;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_rise op=%0d a=%0d b=%0d: got %b want 1", o, x, y, busy);
    end

    cyc = 0;
    got = 0;
    while (cyc < 400 && !got) begin
      @(posedge clk);
      cyc++;
      #1;
      if (inject && cyc == 1) begin
        start = 1'b1; op = ~o; a = 8'hAA; b = 8'h02;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) got = 1;
    end
    start = 1'b0;

    g = sb.pop_front();
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL done_timeout op=%0d a=%0d b=%0d: no done after %0d cycles", o, x, y, cyc);
    end else begin
      if (cyc != g.lat) begin
        failures++;
        $display("FAIL latency op=%0d a=%0d b=%0d: got %0d want %0d", o, x, y, cyc, g.lat);
      end
      checks++;
      if ({result_hi, result_lo} !== g.res) begin
        failures++;
        $display("FAIL result op=%0d a=%0d b=%0d: got %h want %h", o, x, y,
                 {result_hi, result_lo}, g.res);
      end
      checks++;
      if (div_by_zero !== g.dbz) begin
        failures++;
        $display("FAIL dbz op=%0d a=%0d b=%0d: got %b want %b", o, x, y, div_by_zero, g.dbz);
      end
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL busy_in_done op=%0d a=%0d b=%0d: got %b want 1", o, x, y, busy);
      end
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL done_fall op=%0d a=%0d b=%0d: done=%b busy=%b want 0 0", o, x, y, done, busy);
      end
      checks++;
      if ({result_hi, result_lo} !== g.res) begin
        failures++;
        $display("FAIL result_hold op=%0d a=%0d b=%0d: got %h want %h", o, x, y,
                 {result_hi, result_lo}, g.res);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    start = 1'b0; op = 1'b0; a = '0; b = '0;
    w_start = 1'b0; w_op = 1'b0; w_a = '0; w_b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result_lo !== 8'h00 ||
        result_hi !== 8'h00 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h dbz=%b want all 0",
               busy, done, result_hi, result_lo, div_by_zero);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_mul;
    run_op(1'b0, 8'd3,   8'd11,  0);
    run_op(1'b0, 8'd255, 8'd255, 0);
    run_op(1'b0, 8'd0,   8'd200, 0);
    run_op(1'b0, 8'd11,  8'd3,   0);
  endtask

  task automatic test_div;
    run_op(1'b1, 8'd100, 8'd7, 0);
    run_op(1'b1, 8'd5,   8'd9, 0);
    run_op(1'b1, 8'd5,   8'd0, 0);
    run_op(1'b1, 8'd6,   8'd2, 0);
  endtask

  task automatic test_ignore_start;
    run_op(1'b0, 8'd3, 8'd11, 1);
  endtask

  task automatic test_reset_abort;
    bit seen;
    // Leave a nonzero result behind so clearing by reset is observable.
    run_op(1'b1, 8'd7, 8'd2, 0);
    @(negedge clk);
    op = 1'b0; a = 8'd200; b = 8'd200; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result_lo !== 8'h00 ||
        result_hi !== 8'h00 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_abort: busy=%b done=%b hi=%h lo=%h dbz=%b want all 0",
               busy, done, result_hi, result_lo, div_by_zero);
    end
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 260; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen = 1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL abort_no_done: got done pulse want none");
    end
    run_op(1'b0, 8'd200, 8'd200, 0);
  endtask

  task automatic run_wide(input logic [11:0] x, input logic [11:0] y);
    exp12_t e;
    exp12_t g;
    int     cyc;
    bit     got;
    e.res = {12'h000, x} * {12'h000, y};
    e.lat = int'(y) + 1;
    wsb.push_back(e);
    @(negedge clk);
    w_op = 1'b0; w_a = x; w_b = y; w_start = 1'b1;
    @(posedge clk);
    #1;
    w_start = 1'b0;
    cyc = 0;
    got = 0;
    while (cyc < 2000 && !got) begin
      @(posedge clk);
      cyc++;
      #1;
      if (w_done === 1'b1) got = 1;
    end
    g = wsb.pop_front();
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL wide_timeout a=%0d b=%0d: no done after %0d cycles", x, y, cyc);
    end else begin
      if (cyc != g.lat) begin
        failures++;
        $display("FAIL wide_latency a=%0d b=%0d: got %0d want %0d", x, y, cyc, g.lat);
      end
      checks++;
      if ({w_result_hi, w_result_lo} !== g.res || w_div_by_zero !== 1'b0) begin
        failures++;
        $display("FAIL wide_result a=%0d b=%0d: got %h dbz=%b want %h dbz=0", x, y,
                 {w_result_hi, w_result_lo}, w_div_by_zero, g.res);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_wide;
    run_wide(12'd2,    12'd1000);
    run_wide(12'd1000, 12'd2);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_ignore_start();
    test_reset_abort();
    test_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
